// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants and helpers for the FIFO write-side arbiter.
// State encodings are plain localparams so the FSM stays legacy-compatible.
package fifo_ctrl_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side signals of the write arbiter, plus FSM debug taps.
// Handshake: a beat from requester i moves when req_valid[i] && req_ready[i] at a rising clk edge;
// valid must not wait on ready, ready may depend only on state and FIFO level/full.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int WR_PARALLELISM = 128,
  parameter int DEPTH          = 16,
  parameter int NUM_REQ        = 4,
  parameter int MAX_BURST      = 8
);
  localparam int WORD_W = WR_PARALLELISM * DATA_WIDTH;
  localparam int ID_W   = fifo_ctrl_pkg::clog2_min1(NUM_REQ);
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int CNT_W  = $clog2(MAX_BURST + 1);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*WORD_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full;
  logic [LVL_W-1:0]          fifo_level;
  logic                      wr_en;
  logic [WORD_W-1:0]         wr_data;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;
  logic [0:0]                dbg_state;
  logic [CNT_W-1:0]          dbg_beat_cnt;

  modport master (
    input  req_valid, req_last, req_data, fifo_full, fifo_level,
    output req_ready, wr_en, wr_data, grant_id, busy, dbg_state, dbg_beat_cnt
  );

  modport slave (
    output req_valid, req_last, req_data, fifo_full, fifo_level,
    input  req_ready, wr_en, wr_data, grant_id, busy, dbg_state, dbg_beat_cnt
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr.sv
// Combinational rotate-priority pick: first requester above last_grant, wrapping around.
module rr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic               any_valid,
  output logic [ID_W-1:0]    winner
);

  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      logic [ID_W-1:0] idx;
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!any_valid && req[idx]) begin
        any_valid = 1'b1;
        winner    = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded scheduler for the async FIFO write port.
// Throttles on FIFO level with a margin covering the write-enable synchroniser delay.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int WR_PARALLELISM = 128,
  parameter int DEPTH          = 16,
  parameter int NUM_REQ        = 4,
  parameter int MAX_BURST      = 8,
  parameter int AF_MARGIN      = 3
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int WORD_W = WR_PARALLELISM * DATA_WIDTH;
  localparam int ID_W   = clog2_min1(NUM_REQ);
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int CNT_W  = $clog2(MAX_BURST + 1);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic              wr_en_q, wr_en_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;

  logic               space_ok;
  logic               any_valid;
  logic [ID_W-1:0]    winner;
  logic               g_valid, g_last, xfer;
  logic [WORD_W-1:0]  g_data;
  logic [NUM_REQ-1:0] ready_c;

  // The margin leaves room for beats already in flight through the write-side synchroniser.
  assign space_ok = !bus.fifo_full && (bus.fifo_level <= LVL_W'(DEPTH - AF_MARGIN));

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .any_valid  (any_valid),
    .winner     (winner)
  );

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    ready_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        g_valid    = bus.req_valid[i];
        g_last     = bus.req_last[i];
        g_data     = bus.req_data[slice_lo(i, WORD_W) +: WORD_W];
        ready_c[i] = (state_q == ST_BURST) && space_ok;
      end
    end
    xfer = (state_q == ST_BURST) && g_valid && space_ok;
  end

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    wr_en_d      = xfer;
    wr_data_d    = xfer ? g_data : wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid && space_ok) begin
          state_d      = ST_BURST;
          grant_id_d   = winner;
          last_grant_d = winner;
          beat_cnt_d   = '0;
        end
      end
      default: begin
        // Dropping valid releases the grant even while throttled.
        if (!g_valid) begin
          state_d = ST_IDLE;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (g_last || (beat_cnt_d == CNT_W'(MAX_BURST))) begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_cnt_q   <= '0;
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bus.req_ready    = ready_c;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.busy         = (state_q == ST_BURST);
  assign bus.dbg_state    = state_q;
  assign bus.dbg_beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer model drives beats, a monitor checks FIFO writes
// against an expected queue, and the main thread checks grant/ready/busy cycle by cycle.
module tb_fifo_wr_arbiter;

  localparam int DW    = 8;
  localparam int WP    = 4;
  localparam int DEPTH = 16;
  localparam int NR    = 4;
  localparam int MB    = 8;
  localparam int AF    = 3;
  localparam int W     = DW * WP;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_wr_arbiter_if #(
    .DATA_WIDTH(DW), .WR_PARALLELISM(WP), .DEPTH(DEPTH), .NUM_REQ(NR), .MAX_BURST(MB)
  ) bus ();

  fifo_wr_arbiter #(
    .DATA_WIDTH(DW), .WR_PARALLELISM(WP), .DEPTH(DEPTH), .NUM_REQ(NR),
    .MAX_BURST(MB), .AF_MARGIN(AF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int n_vec = 0;
  int n_err = 0;

  // producer model
  logic [NR-1:0] p_on;
  int p_cnt[NR];
  int p_last_at[NR];
  int p_stop_at[NR];

  function automatic logic [W-1:0] word(input int r, input int n);
    return {8'(r), 8'(n), 8'(r ^ n), 8'hC3};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      logic v;
      v = p_on[i] && (p_stop_at[i] < 0 || p_cnt[i] < p_stop_at[i]);
      bus.req_valid[i]         = v;
      bus.req_last[i]          = v && (p_cnt[i] == p_last_at[i]);
      bus.req_data[i*W +: W]   = word(i, p_cnt[i]);
    end
  endtask

  task automatic apply();
    drive_inputs();
    #1;
  endtask

  task automatic step();
    logic [NR-1:0] acc;
    acc = bus.req_valid & bus.req_ready & {NR{!rst}};
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (acc[i]) p_cnt[i]++;
    drive_inputs();
    #1;
  endtask

  task automatic clear_prod();
    p_on = '0;
    for (int i = 0; i < NR; i++) begin
      p_last_at[i] = -1;
      p_stop_at[i] = -1;
    end
  endtask

  task automatic push_burst(input int r, input int first, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(word(r, first + k));
  endtask

  task automatic run_until_idle(input string name);
    int k;
    k = 0;
    while (bus.busy && k < 40) begin
      step();
      k++;
    end
    chk({name, " idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic drain();
    repeat (3) step();
  endtask

  // monitor: every FIFO write must match the next expected word
  always @(posedge clk) begin
    #1;
    if (bus.wr_en === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_data: unexpected write %0h at %0t", bus.wr_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.wr_data !== mon_e) begin
          n_err++;
          $display("FAIL wr_data: got %0h expected %0h at %0t", bus.wr_data, mon_e, $time);
        end
      end
    end
  end

  int order[5] = '{0, 1, 2, 3, 0};
  int base[NR];
  int c0, c1, c2;
  logic [NR-1:0] onehot;

  initial begin
    for (int i = 0; i < NR; i++) p_cnt[i] = 0;
    clear_prod();
    bus.fifo_full  = 1'b0;
    bus.fifo_level = '0;
    apply();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // reset values
    chk("rst wr_en",    32'(bus.wr_en), 32'd0);
    chk("rst wr_data",  32'(bus.wr_data), 32'd0);
    chk("rst ready",    32'(bus.req_ready), 32'd0);
    chk("rst grant",    32'(bus.grant_id), 32'd0);
    chk("rst busy",     32'(bus.busy), 32'd0);
    chk("rst state",    32'(bus.dbg_state), 32'd0);
    chk("rst beat_cnt", 32'(bus.dbg_beat_cnt), 32'd0);

    // 1: single requester, 3-beat burst with last on beat 3
    p_on[0] = 1'b1; p_last_at[0] = 2; p_stop_at[0] = 3;
    push_burst(0, 0, 3);
    apply();
    chk("t1 bubble ready", 32'(bus.req_ready), 32'd0);
    step();
    chk("t1 busy",   32'(bus.busy), 32'd1);
    chk("t1 grant",  32'(bus.grant_id), 32'd0);
    chk("t1 ready0", 32'(bus.req_ready), 32'b0001);
    chk("t1 wr_en0", 32'(bus.wr_en), 32'd0);
    step();
    chk("t1 ready1", 32'(bus.req_ready), 32'b0001);
    chk("t1 wr_en1", 32'(bus.wr_en), 32'd1);
    step();
    chk("t1 ready2", 32'(bus.req_ready), 32'b0001);
    step();
    chk("t1 end busy",  32'(bus.busy), 32'd0);
    chk("t1 end ready", 32'(bus.req_ready), 32'd0);
    chk("t1 end wr_en", 32'(bus.wr_en), 32'd1);
    step();
    chk("t1 wr_en off", 32'(bus.wr_en), 32'd0);
    clear_prod();
    apply();
    drain();

    // 2: all requesters continuously valid -> 8-beat bursts in order 0,1,2,3,0
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) base[i] = p_cnt[i];
    for (int b = 0; b < 5; b++) begin
      push_burst(order[b], base[order[b]], MB);
      base[order[b]] += MB;
    end
    p_on = '1;
    apply();
    for (int b = 0; b < 5; b++) begin
      chk("t2 idle gap", 32'(bus.busy), 32'd0);
      step();
      chk("t2 grant", 32'(bus.grant_id), 32'(order[b]));
      chk("t2 busy",  32'(bus.busy), 32'd1);
      onehot = NR'(1) << order[b];
      for (int k = 0; k < MB; k++) begin
        chk("t2 ready", 32'(bus.req_ready), 32'(onehot));
        step();
      end
    end
    chk("t2 final idle", 32'(bus.busy), 32'd0);
    clear_prod();
    apply();
    drain();

    // 3: level throttle at 14, resume at 13 with beat_cnt continuing
    bus.fifo_level = 5'd12;
    push_burst(2, p_cnt[2], MB);
    p_on[2] = 1'b1;
    apply();
    step();
    chk("t3 grant",     32'(bus.grant_id), 32'd2);
    chk("t3 ready@12",  32'(bus.req_ready), 32'b0100);
    step();
    bus.fifo_level = 5'd13;
    apply();
    chk("t3 ready@13",  32'(bus.req_ready), 32'b0100);
    step();
    bus.fifo_level = 5'd14;
    apply();
    chk("t3 ready@14",  32'(bus.req_ready), 32'd0);
    step();
    chk("t3 hold busy", 32'(bus.busy), 32'd1);
    chk("t3 hold cnt",  32'(bus.dbg_beat_cnt), 32'd2);
    chk("t3 hold wr_en", 32'(bus.wr_en), 32'd0);
    bus.fifo_level = 5'd13;
    apply();
    chk("t3 resume ready", 32'(bus.req_ready), 32'b0100);
    step();
    chk("t3 resume cnt", 32'(bus.dbg_beat_cnt), 32'd3);
    run_until_idle("t3");
    clear_prod();
    bus.fifo_level = '0;
    apply();
    drain();

    // 4: fifo_full with level 0 blocks arbitration
    bus.fifo_full = 1'b1;
    p_on[1] = 1'b1; p_last_at[1] = p_cnt[1] + 1; p_stop_at[1] = p_cnt[1] + 2;
    push_burst(1, p_cnt[1], 2);
    apply();
    repeat (3) begin
      step();
      chk("t4 full busy",  32'(bus.busy), 32'd0);
      chk("t4 full wr_en", 32'(bus.wr_en), 32'd0);
      chk("t4 full ready", 32'(bus.req_ready), 32'd0);
    end
    bus.fifo_full = 1'b0;
    apply();
    step();
    chk("t4 grant", 32'(bus.grant_id), 32'd1);
    chk("t4 busy",  32'(bus.busy), 32'd1);
    run_until_idle("t4");
    clear_prod();
    apply();
    drain();

    // 5: req1 drops valid after 2 beats -> release, req2 granted with beat_cnt from 0
    c1 = p_cnt[1];
    c2 = p_cnt[2];
    push_burst(1, c1, 2);
    push_burst(2, c2, 3);
    p_on[1] = 1'b1; p_stop_at[1] = c1 + 2;
    apply();
    step();
    chk("t5 grant1", 32'(bus.grant_id), 32'd1);
    p_on[2] = 1'b1; p_last_at[2] = c2 + 2; p_stop_at[2] = c2 + 3;
    apply();
    step();
    step();
    chk("t5 still busy", 32'(bus.busy), 32'd1);
    step();
    chk("t5 release", 32'(bus.busy), 32'd0);
    step();
    chk("t5 grant2",  32'(bus.grant_id), 32'd2);
    chk("t5 cnt0",    32'(bus.dbg_beat_cnt), 32'd0);
    run_until_idle("t5");
    clear_prod();
    apply();
    drain();

    // 6: reset in the cycle after an accepted beat
    c1 = p_cnt[1];
    push_burst(1, c1, 1);
    p_on[1] = 1'b1;
    apply();
    step();
    chk("t6 grant1", 32'(bus.grant_id), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6 wr_en",   32'(bus.wr_en), 32'd0);
    chk("t6 busy",    32'(bus.busy), 32'd0);
    chk("t6 ready",   32'(bus.req_ready), 32'd0);
    chk("t6 grant",   32'(bus.grant_id), 32'd0);
    chk("t6 wr_data", 32'(bus.wr_data), 32'd0);
    clear_prod();
    c0 = p_cnt[0];
    c2 = p_cnt[2];
    p_on[0] = 1'b1; p_last_at[0] = c0; p_stop_at[0] = c0 + 1;
    p_on[2] = 1'b1; p_last_at[2] = c2; p_stop_at[2] = c2 + 1;
    push_burst(0, c0, 1);
    push_burst(2, c2, 1);
    apply();
    step();
    chk("t6 regrant0", 32'(bus.grant_id), 32'd0);
    run_until_idle("t6a");
    step();
    chk("t6 next grant2", 32'(bus.grant_id), 32'd2);
    run_until_idle("t6b");
    clear_prod();
    apply();
    drain();

    chk("exp_q empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
